// File: rtl/srcnn_mul_arbiter.sv
// ---------------------------------------------------------------------------
// srcnn_mul_arbiter
//
// Shares one unsigned multiplier among NUM_REQ requesters. A round-robin
// arbiter picks one valid requester per cycle. Its operands go into a
// two-stage pipeline:
//   S1 : operand register (valid, a, b, id)
//   S2 : output register (rsp_valid, rsp_data, rsp_id)
// The multiply is combinational between S1 and S2. With no backpressure the
// block returns one result per cycle, two cycles after the accept.
//
// Ports
//   ap_clk     in   1                  clock, rising edge
//   ap_rst_n   in   1                  asynchronous active-low reset
//   req_valid  in   NUM_REQ            per-requester operand valid
//   req_ready  out  NUM_REQ            per-requester accept (one-hot or zero)
//   req_a      in   NUM_REQ*A_WIDTH    packed operand A, requester i at [i*A_WIDTH +: A_WIDTH]
//   req_b      in   NUM_REQ*B_WIDTH    packed operand B, same packing
//   rsp_valid  out  1                  result valid
//   rsp_ready  in   1                  downstream accept
//   rsp_data   out  P_WIDTH            low P_WIDTH bits of a*b
//   rsp_id     out  clog2(NUM_REQ)     requester that owns rsp_data
//   op_cnt     out  16                 completed responses, wraps at 0xFFFF
// ---------------------------------------------------------------------------
module srcnn_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int A_WIDTH = 5,
    parameter int B_WIDTH = 6,
    parameter int P_WIDTH = 9,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [P_WIDTH-1:0]           rsp_data,
    output logic [ID_W-1:0]              rsp_id,
    output logic [15:0]                  op_cnt
);

    // The product is computed at a width that can hold both the full product
    // and the requested output width. Truncating from there never
    // under-slices.
    localparam int PROD_W = A_WIDTH + B_WIDTH;
    localparam int FULL_W = (PROD_W > P_WIDTH) ? PROD_W : P_WIDTH;

    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic               s1_valid_q, s1_valid_d;
    logic [A_WIDTH-1:0] s1_a_q, s1_a_d;
    logic [B_WIDTH-1:0] s1_b_q, s1_b_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [P_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [15:0]        op_cnt_q, op_cnt_d;

    logic [A_WIDTH-1:0] a_arr [NUM_REQ];
    logic [B_WIDTH-1:0] b_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic [ID_W:0]      cand;
    logic               advance;
    logic               accept_ok;
    logic               accept;
    logic [FULL_W-1:0]  prod_full;

    // Unpack the flat operand buses so the winner's operands can be read
    // with a plain index.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*A_WIDTH +: A_WIDTH];
        assign b_arr[g] = req_b[g*B_WIDTH +: B_WIDTH];
    end

    // Round-robin search. The search starts at last_grant+1 and walks
    // NUM_REQ positions, wrapping modulo NUM_REQ. The candidate index carries
    // one extra bit so the wrap test works for any NUM_REQ, including ones
    // that are not powers of two.
    always_comb begin
        grant_oh  = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_any && req_valid[cand[ID_W-1:0]]) begin
                grant_any                = 1'b1;
                grant_id                 = cand[ID_W-1:0];
                grant_oh[cand[ID_W-1:0]] = 1'b1;
            end
        end
    end

    // S2 and S1 move together whenever the output register is free or is
    // being drained. S1 can take a new operand pair if it is empty or is
    // moving on this cycle. req_ready is also gated by reset so that no
    // requester sees an accept while the block is held in reset.
    assign advance   = !rsp_valid_q || rsp_ready;
    assign accept_ok = !s1_valid_q || advance;
    assign accept    = grant_any && accept_ok;
    assign req_ready = grant_oh & {NUM_REQ{accept_ok && ap_rst_n}};

    assign prod_full = FULL_W'(s1_a_q) * FULL_W'(s1_b_q);

    // Next-state logic for both pipeline stages, the grant pointer and the
    // response counter. Drain, fill and accept are evaluated independently,
    // so all three can happen in the same cycle without a bubble.
    always_comb begin
        last_grant_d = last_grant_q;
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_id_d      = s1_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        op_cnt_d     = op_cnt_q;

        if (rsp_valid_q && rsp_ready) begin
            op_cnt_d = op_cnt_q + 16'd1;
        end

        if (advance) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_data_d = prod_full[P_WIDTH-1:0];
                rsp_id_d   = s1_id_q;
            end
        end

        if (accept_ok) begin
            s1_valid_d = grant_any;
            if (grant_any) begin
                s1_a_d  = a_arr[grant_id];
                s1_b_d  = b_arr[grant_id];
                s1_id_d = grant_id;
            end
        end

        if (accept) begin
            last_grant_d = grant_id;
        end
    end

    // State registers. Reset leaves last_grant pointing at the final
    // requester, so requester 0 wins first.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_id_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            op_cnt_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_id_q      <= s1_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            op_cnt_q     <= op_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_srcnn_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_srcnn_mul_arbiter
//
// Directed testbench for srcnn_mul_arbiter with the default parameters
// (4 requesters, 5x6-bit operands, 9-bit product). Each scenario is a task
// that drives stimulus and checks its results against values worked out by
// hand. Inputs change 1 time unit after a rising edge, and outputs are
// sampled at that same point.
// ---------------------------------------------------------------------------
module tb_srcnn_mul_arbiter;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [19:0] req_a = '0;
    logic [23:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [8:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic [15:0] op_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    srcnn_mul_arbiter dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .op_cnt    (op_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [4:0] a, input logic [5:0] b);
        req_a[i*5 +: 5] = a;
        req_b[i*6 +: 6] = b;
    endtask

    task automatic do_reset();
        ap_rst_n  = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        ap_rst_n = 1'b1;
    endtask

    // Operands a=i+1, b=i+2 for requester i, giving products 2, 6, 12, 20.
    task automatic load_fair_ops();
        for (int i = 0; i < 4; i++) set_op(i, 5'(i + 1), 6'(i + 2));
    endtask

    task automatic test_reset();
        ap_rst_n  = 1'b0;
        req_valid = 4'b1111;
        #1;
        vec_cnt++;
        if (req_ready !== 4'b0000) begin
            err_cnt++;
            $display("[TB] FAIL reset_req_ready got %b want 0000", req_ready);
        end
        vec_cnt++;
        if (rsp_valid !== 1'b0 || rsp_data !== 9'd0 || rsp_id !== 2'd0 || op_cnt !== 16'd0) begin
            err_cnt++;
            $display("[TB] FAIL reset_outputs got v=%b d=%h id=%0d cnt=%0d want 0/0/0/0",
                     rsp_valid, rsp_data, rsp_id, op_cnt);
        end
        do_reset();
    endtask

    task automatic test_single_op();
        do_reset();
        rsp_ready = 1'b1;
        set_op(2, 5'd31, 6'd63);
        req_valid = 4'b0100;
        #1;
        vec_cnt++;
        if (req_ready !== 4'b0100) begin
            err_cnt++;
            $display("[TB] FAIL single_ready got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        vec_cnt++;
        if (rsp_valid !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL single_early got rsp_valid=%b want 0", rsp_valid);
        end
        tick();
        vec_cnt++;
        if (rsp_valid !== 1'b1 || rsp_data !== 9'h1A1 || rsp_id !== 2'd2) begin
            err_cnt++;
            $display("[TB] FAIL single_rsp got v=%b d=%h id=%0d want 1/1a1/2",
                     rsp_valid, rsp_data, rsp_id);
        end
        tick();
        vec_cnt++;
        if (op_cnt !== 16'd1 || rsp_valid !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL single_cnt got cnt=%0d v=%b want 1/0", op_cnt, rsp_valid);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_rdy;
        int         id;
        do_reset();
        load_fair_ops();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        for (int c = 0; c < 10; c++) begin
            exp_rdy = 4'b0001 << (c % 4);
            vec_cnt++;
            if (req_ready !== exp_rdy) begin
                err_cnt++;
                $display("[TB] FAIL fair_grant c=%0d got %b want %b", c, req_ready, exp_rdy);
            end
            if (c >= 2) begin
                id = (c - 2) % 4;
                vec_cnt++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(id) || rsp_data !== 9'((id + 1) * (id + 2))) begin
                    err_cnt++;
                    $display("[TB] FAIL fair_rsp c=%0d got v=%b id=%0d d=%0d want 1/%0d/%0d",
                             c, rsp_valid, rsp_id, rsp_data, id, (id + 1) * (id + 2));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        load_fair_ops();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        vec_cnt++;
        if (req_ready !== 4'b0001) begin
            err_cnt++;
            $display("[TB] FAIL bp_acc0 got %b want 0001", req_ready);
        end
        tick();
        vec_cnt++;
        if (req_ready !== 4'b0010) begin
            err_cnt++;
            $display("[TB] FAIL bp_acc1 got %b want 0010", req_ready);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            vec_cnt++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 9'd2) begin
                err_cnt++;
                $display("[TB] FAIL bp_stall c=%0d got rdy=%b v=%b id=%0d d=%0d want 0000/1/0/2",
                         c, req_ready, rsp_valid, rsp_id, rsp_data);
            end
            if (c < 2) tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        vec_cnt++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 9'd6) begin
            err_cnt++;
            $display("[TB] FAIL bp_drain got v=%b id=%0d d=%0d want 1/1/6", rsp_valid, rsp_id, rsp_data);
        end
        tick();
        vec_cnt++;
        if (rsp_valid !== 1'b0 || op_cnt !== 16'd2) begin
            err_cnt++;
            $display("[TB] FAIL bp_end got v=%b cnt=%0d want 0/2", rsp_valid, op_cnt);
        end
    endtask

    task automatic test_skip();
        logic [3:0] exp_rdy;
        int         id;
        do_reset();
        set_op(0, 5'd1, 6'd1);
        set_op(2, 5'd1, 6'd1);
        set_op(1, 5'd3, 6'd5);
        set_op(3, 5'd7, 6'd9);
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        #1;
        for (int c = 0; c < 6; c++) begin
            exp_rdy = (c % 2 == 0) ? 4'b0010 : 4'b1000;
            vec_cnt++;
            if (req_ready !== exp_rdy) begin
                err_cnt++;
                $display("[TB] FAIL skip_grant c=%0d got %b want %b", c, req_ready, exp_rdy);
            end
            if (c >= 2) begin
                id = (c % 2 == 0) ? 1 : 3;
                vec_cnt++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(id) || rsp_data !== ((id == 1) ? 9'd15 : 9'd63)) begin
                    err_cnt++;
                    $display("[TB] FAIL skip_rsp c=%0d got v=%b id=%0d d=%0d want 1/%0d/%0d",
                             c, rsp_valid, rsp_id, rsp_data, id, (id == 1) ? 15 : 63);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        load_fair_ops();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        repeat (4) tick();
        rsp_ready = 1'b0;
        #1;
        vec_cnt++;
        if (op_cnt !== 16'd2 || rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
            err_cnt++;
            $display("[TB] FAIL mid_pre got cnt=%0d v=%b rdy=%b want 2/1/0000", op_cnt, rsp_valid, req_ready);
        end
        #1;
        ap_rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (rsp_valid !== 1'b0 || op_cnt !== 16'd0 || req_ready !== 4'b0000 || rsp_data !== 9'd0) begin
            err_cnt++;
            $display("[TB] FAIL mid_async got v=%b cnt=%0d rdy=%b d=%0d want 0/0/0000/0",
                     rsp_valid, op_cnt, req_ready, rsp_data);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        ap_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vec_cnt++;
            if (rsp_valid !== 1'b0 || op_cnt !== 16'd0) begin
                err_cnt++;
                $display("[TB] FAIL mid_stale c=%0d got v=%b cnt=%0d want 0/0", c, rsp_valid, op_cnt);
            end
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        load_fair_ops();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        repeat (65537) tick();
        vec_cnt++;
        if (op_cnt !== 16'hFFFF) begin
            err_cnt++;
            $display("[TB] FAIL wrap_max got %h want ffff", op_cnt);
        end
        tick();
        vec_cnt++;
        if (op_cnt !== 16'h0000) begin
            err_cnt++;
            $display("[TB] FAIL wrap_zero got %h want 0000", op_cnt);
        end
        req_valid = '0;
    endtask

    initial begin
        #1;
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_skip();
        test_reset_midflight();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/srcnn_mul_arbiter.md
SRCNN_MUL_ARBITER -- requirements
Module: srcnn_mul_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing one multiplier (2..8).
REQ-002 The block SHALL have parameter A_WIDTH, default 5, meaning unsigned operand A width.
REQ-003 The block SHALL have parameter B_WIDTH, default 6, meaning unsigned operand B width.
REQ-004 The block SHALL have parameter P_WIDTH, default 9, meaning product width delivered on rsp_data.
REQ-005 The block SHALL have port ap_clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port ap_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 The block SHALL have port req_valid  input  NUM_REQ  per-requester operand valid.
REQ-008 The block SHALL have port req_ready  output  NUM_REQ  per-requester accept, at most one bit high.
REQ-009 The block SHALL have port req_a  input  NUM_REQ*A_WIDTH  packed operand A; requester i at bits [i*A_WIDTH +: A_WIDTH].
REQ-010 The block SHALL have port req_b  input  NUM_REQ*B_WIDTH  packed operand B, same packing.
REQ-011 The block SHALL have port rsp_valid  output  1  result valid.
REQ-012 The block SHALL have port rsp_ready  input  1  downstream accept.
REQ-013 The block SHALL have port rsp_data  output  P_WIDTH  product.
REQ-014 The block SHALL have port rsp_id  output  clog2(NUM_REQ)  index of the requester that owns rsp_data.
REQ-015 The block SHALL have port op_cnt  output  16  count of completed responses.

Function
REQ-016 Arithmetic SHALL be unsigned: rsp_data = low P_WIDTH bits of (zero-extended A * zero-extended B); upper bits silently discarded.
REQ-017 Transfer on a channel SHALL occur only in a cycle where valid and ready are both high; requesters must hold req_a/req_b stable while req_valid high and not accepted.
REQ-018 The pipeline SHALL be two stages: S1 operand register (s1_valid, a, b, id), S2 output register driving rsp_valid/rsp_data/rsp_id.
REQ-019 S2 SHALL advance when rsp_valid==0 or rsp_ready==1; S1 SHALL advance into S2 under the same condition; multiply is computed combinationally from S1 into S2.
REQ-020 A new request SHALL be accepted into S1 when s1_valid==0 or S1 advances in that cycle.
REQ-021 Latency: request accepted in cycle t SHALL appear with rsp_valid high in cycle t+2 if no backpressure; throughput SHALL be one result per cycle.
REQ-022 Arbitration SHALL be round-robin: grant goes to the first requester with req_valid high searching from (last_grant+1) modulo NUM_REQ upward.
REQ-023 last_grant SHALL update only on an actual accept; an ungranted or withdrawn request SHALL not move the pointer.
REQ-024 req_ready SHALL be the one-hot grant ANDed with the S1-accept condition; all zero when no req_valid or pipeline stalled.
REQ-025 rsp_valid, rsp_data, rsp_id SHALL hold stable while rsp_valid==1 and rsp_ready==0.
REQ-026 op_cnt SHALL increment by 1 on each rsp_valid&&rsp_ready and wrap 0xFFFF -> 0x0000.
REQ-027 Simultaneous S2 drain and S1 fill and new accept in one cycle SHALL all take effect without bubble or loss.

Reset
REQ-028 ap_rst_n low SHALL immediately (asynchronously) clear s1_valid, rsp_valid, op_cnt to 0; rsp_data, rsp_id to 0; last_grant to NUM_REQ-1 so requester 0 has first priority.
REQ-029 Reset mid-operation SHALL discard in-flight operands; no response for them SHALL appear after release, and req_ready SHALL be 0 while ap_rst_n low.

Verification
REQ-030 Single op: requester 2 a=31 b=63, rsp_ready=1 -> rsp_valid two cycles after accept, rsp_data=0x1A1 (1953 truncated), rsp_id=2, op_cnt=1.
REQ-031 Fairness: all four req_valid held high, rsp_ready=1 after reset -> accept order 0,1,2,3,0,1..., one accept per cycle, rsp_id sequence matches.
REQ-032 Backpressure: continuous requests, rsp_ready=0 -> exactly two accepts then req_ready all 0, rsp_data frozen; rsp_ready=1 -> results drain in order, no loss or duplication.
REQ-033 Withdrawal/skip: only requesters 1 and 3 valid (a=3,b=5 and a=7,b=9) -> alternating grants, results 15 and 63, requesters 0/2 never granted.
REQ-034 Reset mid-flight: S1 and S2 full, ap_rst_n pulsed low -> rsp_valid drops same cycle, op_cnt=0, no stale response after release.
REQ-035 Counter wrap: 65536 completed responses -> op_cnt returns to 0x0000.
